// File: rtl/debug_unit_pkg.sv
// debug_unit shared constants and state encoding.
// Command bytes, dump length and controller FSM states.
package debug_unit_pkg;

  localparam int DBG_DATA_WIDTH = 32;
  localparam int DBG_IMEM_AW    = 8;

  localparam logic [7:0] DBG_CMD_LOAD = 8'h4C;
  localparam logic [7:0] DBG_CMD_RUN  = 8'h52;
  localparam logic [7:0] DBG_CMD_STEP = 8'h53;
  localparam logic [7:0] DBG_CMD_DUMP = 8'h44;
  localparam logic [7:0] DBG_ACK      = 8'h4B;

  localparam int DBG_DUMP_BYTES = 132;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CNT,
    S_LOAD_DATA,
    S_LOAD_ACK,
    S_RUN,
    S_STEP,
    S_SEND
  } dbg_state_e;

endpackage

// File: rtl/debug_unit_if.sv
// Byte stream bundle between the UART byte layer and debug_unit.
// rx is a one-cycle strobe; tx is a valid/ready handshake.
interface debug_unit_if;
  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic       o_tx_valid;
  logic [7:0] o_tx_data;
  logic       i_tx_ready;

  modport slave (
    input  i_rx_valid, i_rx_data, i_tx_ready,
    output o_tx_valid, o_tx_data
  );

  modport master (
    output i_rx_valid, i_rx_data, i_tx_ready,
    input  o_tx_valid, o_tx_data
  );
endinterface

// File: rtl/debug_tx_serializer.sv
// Holding-register tx serializer: single ack byte or PC+regs dump.
// Bytes go out MSB-first, at most one byte every two cycles.
module debug_tx_serializer
  import debug_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DBG_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ack_mode,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic [4:0]            reg_addr,
  output logic                  done
);

  logic                  active;
  logic                  ack;
  logic [7:0]            idx;
  logic [7:0]            rel;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] sh;
  logic                  last;

  assign rel      = idx - 8'd4;
  assign reg_addr = (idx < 8'd4) ? 5'd0 : rel[6:2];
  assign word     = (idx < 8'd4) ? pc_q : reg_data;
  assign sh       = word << {idx[1:0], 3'b000};
  assign last     = ack || (idx == 8'(DBG_DUMP_BYTES - 1));
  assign done     = tx_valid && tx_ready && last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      ack      <= 1'b0;
      idx      <= 8'd0;
      pc_q     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
    end else if (start) begin
      active   <= 1'b1;
      ack      <= ack_mode;
      idx      <= 8'd0;
      pc_q     <= pc;
      tx_valid <= 1'b0;
    end else if (active) begin
      if (tx_valid) begin
        if (tx_ready) begin
          tx_valid <= 1'b0;
          if (last) begin
            active <= 1'b0;
            idx    <= 8'd0;
          end else begin
            idx <= idx + 8'd1;
          end
        end
      end else begin
        tx_valid <= 1'b1;
        tx_data  <= ack ? DBG_ACK : sh[DATA_WIDTH-1 -: 8];
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Debug controller: program load, run-to-halt, single step, dump.
// Holds the core in reset while loading instruction memory.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = DBG_DATA_WIDTH,
  parameter int IMEM_ADDR_WIDTH = DBG_IMEM_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  debug_unit_if.slave                strm,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0]      o_imem_wdata,
  output logic                       o_cpu_en,
  output logic                       o_cpu_reset,
  input  logic                       i_halt,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [4:0]                 o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic                       o_busy
);

  localparam logic [IMEM_ADDR_WIDTH-1:0] ADDR_ONE = IMEM_ADDR_WIDTH'(1);

  dbg_state_e            state;
  logic [DATA_WIDTH-9:0] asm_q;
  logic [DATA_WIDTH-1:0] word;
  logic [1:0]            bcnt;
  logic [7:0]            words;
  logic                  ser_start;
  logic                  ser_ack;
  logic                  ser_done;
  logic                  rx;
  logic [7:0]            rxd;

  assign rx       = strm.i_rx_valid;
  assign rxd      = strm.i_rx_data;
  assign word     = {asm_q, rxd};
  assign o_busy   = (state != S_IDLE);
  assign o_cpu_en = ((state == S_RUN) && !i_halt) || (state == S_STEP);

  debug_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .start    (ser_start),
    .ack_mode (ser_ack),
    .pc       (i_pc),
    .reg_data (i_reg_data),
    .tx_ready (strm.i_tx_ready),
    .tx_valid (strm.o_tx_valid),
    .tx_data  (strm.o_tx_data),
    .reg_addr (o_reg_addr),
    .done     (ser_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      o_cpu_reset  <= 1'b1;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      asm_q        <= '0;
      bcnt         <= 2'd0;
      words        <= 8'd0;
      ser_start    <= 1'b0;
      ser_ack      <= 1'b0;
    end else begin
      o_imem_we <= 1'b0;
      ser_start <= 1'b0;
      // address advances in the cycle after each write strobe
      if (o_imem_we) o_imem_addr <= o_imem_addr + ADDR_ONE;
      unique case (state)
        S_IDLE: begin
          if (rx) begin
            unique case (1'b1)
              (rxd == DBG_CMD_LOAD): begin
                state       <= S_LOAD_CNT;
                o_cpu_reset <= 1'b1;
              end
              (rxd == DBG_CMD_RUN): begin
                state       <= S_RUN;
                o_cpu_reset <= 1'b0;
              end
              (rxd == DBG_CMD_STEP): begin
                state       <= S_STEP;
                o_cpu_reset <= 1'b0;
              end
              (rxd == DBG_CMD_DUMP): begin
                state       <= S_SEND;
                o_cpu_reset <= 1'b0;
                ser_start   <= 1'b1;
                ser_ack     <= 1'b0;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_LOAD_CNT: begin
          if (rx) begin
            if (rxd == 8'd0) begin
              state       <= S_LOAD_ACK;
              o_cpu_reset <= 1'b0;
              ser_start   <= 1'b1;
              ser_ack     <= 1'b1;
            end else begin
              state       <= S_LOAD_DATA;
              o_imem_addr <= '0;
              words       <= rxd;
              bcnt        <= 2'd0;
            end
          end
        end
        S_LOAD_DATA: begin
          if (rx) begin
            asm_q <= word[DATA_WIDTH-9:0];
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              o_imem_we    <= 1'b1;
              o_imem_wdata <= word;
              words        <= words - 8'd1;
              if (words == 8'd1) begin
                state       <= S_LOAD_ACK;
                o_cpu_reset <= 1'b0;
                ser_start   <= 1'b1;
                ser_ack     <= 1'b1;
              end
            end
          end
        end
        S_LOAD_ACK: if (ser_done) state <= S_IDLE;
        S_RUN: begin
          if (i_halt) begin
            state     <= S_SEND;
            ser_start <= 1'b1;
            ser_ack   <= 1'b0;
          end
        end
        S_STEP: begin
          state     <= S_SEND;
          ser_start <= 1'b1;
          ser_ack   <= 1'b0;
        end
        S_SEND: if (ser_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/debug_unit.md
# debug_unit

Byte-stream debug controller that sits directly upstream of the `mips` pipeline top. It loads programs into instruction memory, holds the core in reset while loading, and gates execution with run-to-halt and single-step commands. After each execution command it streams the PC and all 32 registers back over a byte transmit channel. The UART byte layer connects on the stream side.

## Interface
- `DATA_WIDTH`, 32, CPU word width (`DATA_WIDTH` from `mips_pkg.vh`)
- `IMEM_ADDR_WIDTH`, 8, instruction-memory word-address width
- `clk`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `i_rx_valid`  in  1  one-cycle strobe, `i_rx_data` valid; no backpressure
- `i_rx_data`  in  8  received byte
- `o_tx_valid`  out  1  byte available on `o_tx_data`
- `o_tx_data`  out  8  transmit byte
- `i_tx_ready`  in  1  sink accepts byte this cycle
- `o_imem_we`  out  1  instruction-memory write strobe
- `o_imem_addr`  out  `IMEM_ADDR_WIDTH`  word address
- `o_imem_wdata`  out  `DATA_WIDTH`  instruction word
- `o_cpu_en`  out  1  pipeline advance enable
- `o_cpu_reset`  out  1  active-high reset to `mips`
- `i_halt`  in  1  `mips` halt flag
- `i_pc`  in  `DATA_WIDTH`  current IF PC
- `o_reg_addr`  out  5  register-bank debug read address
- `i_reg_data`  in  `DATA_WIDTH`  combinational read data for `o_reg_addr`
- `o_busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD_CNT, LOAD_DATA, LOAD_ACK, RUN, STEP, SEND.
- IDLE command bytes:
  - 0x4C 'L' goes to LOAD_CNT.
  - 0x52 'R' goes to RUN.
  - 0x53 'S' goes to STEP.
  - 0x44 'D' goes to SEND.
  - Any other byte is ignored and the state stays IDLE.
- LOAD_CNT:
  - Takes the next rx byte as word count N.
  - N=0 goes straight to LOAD_ACK. Otherwise it clears the word address to 0 and goes to LOAD_DATA.
- LOAD_DATA:
  - Assembles bytes MSB-first into a word.
  - On the 4th byte, pulses `o_imem_we` for 1 cycle with the current address and word, then increments the address.
  - After N words, goes to LOAD_ACK.
  - Address wraps modulo 2^`IMEM_ADDR_WIDTH`.
- LOAD_ACK: sends 0x4B, then returns to IDLE.
- `o_cpu_reset`:
  - Is 1 from reset release through LOAD_CNT and LOAD_DATA.
  - Drops to 0 on entry to LOAD_ACK.
  - Is 0 in all other states.
- RUN:
  - `o_cpu_en` = ~`i_halt` (combinational). No cycle runs past halt.
  - The first cycle in which `i_halt`=1 goes to SEND. If `i_halt` is already 1 on entry, zero cycles execute.
- STEP: `o_cpu_en`=1 for exactly one cycle, then SEND.
- SEND:
  - Streams 132 bytes: `i_pc` (4 bytes), then registers 0..31 (4 bytes each), all MSB-first.
  - Byte index 0..131; `o_reg_addr` = (index−4)>>2.
  - `i_reg_data` is sampled when each byte is loaded into the tx register.
  - The PC is captured at SEND entry.
  - Returns to IDLE after byte 131 is accepted.
- Rx bytes arriving in RUN, STEP, SEND or LOAD_ACK are dropped.
- `o_cpu_en`=0 in every state except RUN and STEP.

## Timing
- Reset values:
  - State IDLE.
  - `o_cpu_reset`=1, `o_cpu_en`=0, `o_tx_valid`=0, `o_imem_we`=0, `o_busy`=0.
  - `o_imem_addr`=0, `o_imem_wdata`=0, `o_tx_data`=0, `o_reg_addr`=0.
- Command byte in cycle t sets the state at t+1. STEP asserts `o_cpu_en` only in cycle t+1.
- `o_imem_we` is asserted in the cycle after the 4th byte strobe.
- Tx handshake:
  - A transfer happens when `o_tx_valid` and `i_tx_ready` are both high.
  - Data holds stable until accepted.
  - The next byte is presented at the earliest on the following cycle, so there is at most 1 byte per 2 cycles.
- Reset asserted mid-operation: immediate return to reset values. A partial load leaves already-written words in memory.

## Structure
- In `mips_pkg.vh`:
  - Command codes `DBG_CMD_LOAD`, `DBG_CMD_RUN`, `DBG_CMD_STEP`, `DBG_CMD_DUMP`, `DBG_ACK`.
  - State encodings.
  - `DBG_DUMP_BYTES` = 132.
- One natural sub-module: `debug_tx_serializer`. It takes a word-indexed byte counter plus a valid/ready holding register and produces the MSB-first byte stream.

## Test plan
- Load: 'L',0x02,0x20,0x01,0x00,0x0A,0x20,0x02,0x00,0x14 -> writes addr0=0x2001000A and addr1=0x20020014, one 0x4B on tx, `o_cpu_reset` falls at LOAD_ACK.
- Step with `i_pc` model = 4: 'S' -> `o_cpu_en` high exactly 1 cycle, then 132 bytes, first four 0x00,0x00,0x00,0x04, reg k bytes match model value k*3.
- Run: `i_halt` stub rises 10 cycles after 'R' -> `o_cpu_en` high exactly 10 cycles, 0 while halt high, dump follows. 'R' sent with halt already high -> 0 enable cycles.
- Backpressure: `i_tx_ready` pseudo-random 30% during dump -> exactly 132 bytes, no duplicate or missing byte, data stable while stalled.
- Ignored input: 0x00, 0x7F in IDLE and 'L' during SEND -> no state change, no imem write.
- Reset mid-load after 1.5 words -> all outputs at reset values, only addr0 written, next 'D' gives a normal dump.
